// File: rtl/wb_ctrl.sv
// Writeback controller: clears the register file after reset, then drains a
// 2-entry writeback FIFO into it and bypasses queued data to the read ports.
module wb_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_valid,
   output logic        wb_ready,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] out1,
   input  logic [31:0] out2,
   output logic        reg_write,
   output logic [4:0]  rd,
   output logic [31:0] write_data,
   output logic [31:0] fwd1,
   output logic [31:0] fwd2,
   output logic        init_done
);

   typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic [1:0]  occ;
   logic        wp;
   logic        rp;
   logic        tl;
   logic        push;
   logic        pop;
   logic [4:0]  q_rd   [2];
   logic [31:0] q_data [2];

   assign wb_ready = (occ < 2'd2) && (state != IDLE);
   // x0 requests complete the handshake but are dropped here
   assign push = wb_valid && wb_ready && (wb_rd != 5'd0);
   assign pop  = (state == RUN) && (occ != 2'd0);
   assign tl   = ~rp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 5'd1;
         init_done <= 1'b0;
      end else begin
         unique case (state)
            IDLE: state <= CLEAR;
            CLEAR: begin
               if (cnt == 5'd31) begin
                  state     <= RUN;
                  cnt       <= 5'd1;
                  init_done <= 1'b1;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            RUN:     state <= RUN;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp  <= 1'b0;
         rp  <= 1'b0;
         occ <= 2'd0;
      end else begin
         if (push) wp <= ~wp;
         if (pop)  rp <= ~rp;
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_rd[wp]   <= wb_rd;
         q_data[wp] <= wb_data;
      end
   end

   always_comb begin
      reg_write  = 1'b0;
      rd         = 5'd0;
      write_data = 32'd0;
      if (state == CLEAR) begin
         reg_write = 1'b1;
         rd        = cnt;
      end else if (pop) begin
         reg_write  = 1'b1;
         rd         = q_rd[rp];
         write_data = q_data[rp];
      end
   end

   // Youngest queued entry wins; until RUN the register file is stale
   function automatic logic [31:0] bypass(input logic [4:0]  rs,
                                          input logic [31:0] raw);
      logic [31:0] v;
      if (rs == 5'd0)
         v = 32'd0;
      else if (occ == 2'd2 && q_rd[tl] == rs)
         v = q_data[tl];
      else if (occ != 2'd0 && q_rd[rp] == rs)
         v = q_data[rp];
      else if (state != RUN)
         v = 32'd0;
      else
         v = raw;
      return v;
   endfunction

   assign fwd1 = bypass(rs1, out1);
   assign fwd2 = bypass(rs2, out2);

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench for wb_ctrl: clear sequence, writeback, back-pressure,
// x0 drop, simultaneous push/pop and reset during operation.
module tb_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] out1;
   logic [31:0] out2;
   logic        reg_write;
   logic [4:0]  rd;
   logic [31:0] write_data;
   logic [31:0] fwd1;
   logic [31:0] fwd2;
   logic        init_done;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   wb_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .rs1        (rs1),
      .rs2        (rs2),
      .out1       (out1),
      .out2       (out2),
      .reg_write  (reg_write),
      .rd         (rd),
      .write_data (write_data),
      .fwd1       (fwd1),
      .fwd2       (fwd2),
      .init_done  (init_done)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Entered at the negedge where cnt=1; leaves at the first RUN negedge.
   task automatic run_clear(input bit bp, input logic [4:0] prd,
                            input logic [31:0] da, input logic [31:0] db);
      for (int i = 1; i <= 31; i++) begin
         if (bp && i == 3) begin
            wb_valid = 1'b1;
            wb_rd    = prd;
            wb_data  = da;
         end else if (bp && i == 4) begin
            wb_data = db;
         end else begin
            wb_valid = 1'b0;
         end
         #1;
         chk("clr_we", reg_write, 1);
         chk("clr_rd", rd, i);
         chk("clr_wd", write_data, 0);
         chk("clr_done", init_done, 0);
         if (i == 2) begin
            chk("clr_ready", wb_ready, 1);
            chk("clr_fwd1", fwd1, 0);
         end
         if (bp && i == 4) chk("bp_ready1", wb_ready, 1);
         if (bp && i == 5) begin
            chk("bp_ready0", wb_ready, 0);
            chk("bp_fwd2", fwd2, db);
         end
         @(negedge clk);
      end
      #1;
      chk("run_done", init_done, 1);
   endtask

   initial begin
      rst_n    = 1'b0;
      wb_valid = 1'b0;
      wb_rd    = 5'd0;
      wb_data  = 32'd0;
      rs1      = 5'd7;
      rs2      = 5'd5;
      out1     = 32'h1111_1111;
      out2     = 32'h2222_2222;

      @(negedge clk);
      chk("rst_we", reg_write, 0);
      chk("rst_ready", wb_ready, 0);
      chk("rst_done", init_done, 0);
      chk("rst_rd", rd, 0);
      rst_n = 1'b1;
      #1;
      chk("idle_we", reg_write, 0);
      chk("idle_ready", wb_ready, 0);
      chk("idle_fwd1", fwd1, 0);
      @(negedge clk);

      // back-pressure during CLEAR, drained in order in RUN
      run_clear(1'b1, 5'd5, 32'hA, 32'hB);
      chk("bp_we_a", reg_write, 1);
      chk("bp_rd_a", rd, 5);
      chk("bp_wd_a", write_data, 32'hA);
      chk("bp_fwd2_both", fwd2, 32'hB);
      @(negedge clk); #1;
      chk("bp_we_b", reg_write, 1);
      chk("bp_wd_b", write_data, 32'hB);
      chk("bp_fwd2_one", fwd2, 32'hB);
      @(negedge clk); #1;
      chk("bp_we_idle", reg_write, 0);
      chk("bp_fwd2_raw", fwd2, 32'h2222_2222);

      // single writeback with bypass
      wb_valid = 1'b1;
      wb_rd    = 5'd3;
      wb_data  = 32'd7;
      rs1      = 5'd3;
      #1;
      chk("sw_fwd1_pre", fwd1, 32'h1111_1111);
      @(negedge clk);
      wb_valid = 1'b0;
      #1;
      chk("sw_we", reg_write, 1);
      chk("sw_rd", rd, 3);
      chk("sw_wd", write_data, 7);
      chk("sw_fwd1", fwd1, 7);
      @(negedge clk); #1;
      chk("sw_we_off", reg_write, 0);
      chk("sw_rd_off", rd, 0);

      // x0 request is accepted but never written
      wb_valid = 1'b1;
      wb_rd    = 5'd0;
      wb_data  = 32'hFFFF_FFFF;
      rs1      = 5'd0;
      #1;
      chk("x0_ready", wb_ready, 1);
      @(negedge clk);
      wb_valid = 1'b0;
      #1;
      chk("x0_we", reg_write, 0);
      chk("x0_fwd1", fwd1, 0);
      chk("x0_ready2", wb_ready, 1);

      // push and pop on the same edge
      wb_valid = 1'b1;
      wb_rd    = 5'd4;
      wb_data  = 32'h40;
      @(negedge clk);
      wb_rd   = 5'd6;
      wb_data = 32'h60;
      #1;
      chk("pp_we_a", reg_write, 1);
      chk("pp_rd_a", rd, 4);
      chk("pp_wd_a", write_data, 32'h40);
      chk("pp_ready", wb_ready, 1);
      @(negedge clk);
      wb_valid = 1'b0;
      #1;
      chk("pp_we_b", reg_write, 1);
      chk("pp_rd_b", rd, 6);
      chk("pp_wd_b", write_data, 32'h60);
      @(negedge clk); #1;
      chk("pp_empty", reg_write, 0);

      // reset mid-RUN with two entries queued
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rs2 = 5'd9;
      run_clear(1'b1, 5'd9, 32'h91, 32'h92);
      chk("mr_we", reg_write, 1);
      chk("mr_rd", rd, 9);
      chk("mr_wd", write_data, 32'h91);
      rst_n = 1'b0;
      #1;
      chk("mr_rst_we", reg_write, 0);
      chk("mr_rst_ready", wb_ready, 0);
      chk("mr_rst_done", init_done, 0);
      chk("mr_rst_rd", rd, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_clear(1'b0, 5'd0, 32'd0, 32'd0);
      chk("mr_no_we", reg_write, 0);
      chk("mr_fwd2", fwd2, 32'h2222_2222);
      @(negedge clk); #1;
      chk("mr_no_we2", reg_write, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/wb_ctrl.md
WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous, active-low.
REQ-002 SHALL provide these ports (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- wb_valid, in, 1: writeback request from pipeline.
- wb_ready, out, 1: request accepted when wb_valid and wb_ready are both 1 at a rising edge.
- wb_rd, in, 5: destination register.
- wb_data, in, 32: data to write.
- rs1, in, 5: register-file read address 1 (shared with the register file).
- rs2, in, 5: register-file read address 2 (shared with the register file).
- out1, in, 32: raw register-file read data, port 1.
- out2, in, 32: raw register-file read data, port 2.
- reg_write, out, 1: register-file write enable.
- rd, out, 5: register-file write address.
- write_data, out, 32: register-file write data.
- fwd1, out, 32: bypassed read data for rs1.
- fwd2, out, 32: bypassed read data for rs2.
- init_done, out, 1: register file cleared and controller running.

Function
REQ-003 SHALL implement an FSM with states IDLE, CLEAR and RUN; reset state is IDLE.
REQ-004 SHALL move IDLE->CLEAR on the first rising edge with rst_n high.
REQ-005 SHALL, in CLEAR, drive reg_write=1, write_data=0 and rd=cnt, where cnt is a 5-bit counter starting at 1 and incrementing each cycle.
REQ-006 SHALL move CLEAR->RUN on the edge where cnt=31, giving exactly 31 clear cycles; register x0 is never written.
REQ-007 SHALL register init_done: 0 in IDLE and CLEAR, 1 from the first RUN cycle onward.
REQ-008 SHALL buffer accepted requests in a 2-entry FIFO with 2-bit occupancy.
REQ-009 SHALL make wb_ready combinational: 1 when occupancy<2 and state is not IDLE; accepts are therefore possible during CLEAR.
REQ-010 SHALL complete the handshake for a request with wb_rd=0 but SHALL NOT enqueue it.
REQ-011 SHALL, in RUN with the FIFO non-empty, drive reg_write=1 with rd/write_data equal to the FIFO head, and pop the head at that rising edge.
REQ-012 SHALL drive reg_write=0 and rd=0, write_data=0 in RUN with an empty FIFO and in IDLE.
REQ-013 SHALL give an entry accepted at edge N into an empty FIFO in RUN reg_write=1 during cycle N+1; minimum latency is 1 cycle.
REQ-014 SHALL handle simultaneous push and pop in the same edge: occupancy is unchanged and ordering is preserved.
REQ-015 SHALL wrap the FIFO read and write pointers modulo 2.
REQ-016 SHALL compute fwd1 combinationally with this priority:
- 0 if rs1=0;
- else the youngest FIFO entry whose rd equals rs1 (this includes the head being written this cycle);
- else 0 if state is IDLE or CLEAR;
- else out1.
REQ-017 SHALL compute fwd2 identically using rs2 and out2.
REQ-018 SHALL never drive reg_write=1 with rd=0.

Reset
REQ-019 SHALL, on rst_n low, immediately and asynchronously set:
- state=IDLE, cnt=1, FIFO empty, pointers=0, init_done=0;
- outputs reg_write=0, wb_ready=0.
REQ-020 SHALL, on reset asserted mid-CLEAR or mid-RUN, discard pending FIFO entries and restart the full clear sequence after release.

Verification
REQ-021 SHALL cover the clear sequence: release rst_n -> rd steps 1..31 with write_data=0 and reg_write=1; init_done rises on the cycle after rd=31.
REQ-022 SHALL cover single writeback: in RUN, accept wb_rd=3, wb_data=7 -> next cycle reg_write=1, rd=3, write_data=7; with rs1=3 then, fwd1=7.
REQ-023 SHALL cover back-pressure: during CLEAR accept rd=5 (data 0xA) and rd=5 (data 0xB) -> wb_ready drops to 0; after RUN, writes occur in order 0xA then 0xB; fwd for rs2=5 returns 0xB while both entries are queued.
REQ-024 SHALL cover x0 handling: accept wb_rd=0, wb_data=0xFFFF_FFFF -> wb_ready stays 1, no reg_write pulse; rs1=0 gives fwd1=0.
REQ-025 SHALL cover simultaneous events: with the FIFO holding 1 entry, push and pop on the same edge -> occupancy stays 1 and the data order is correct.
REQ-026 SHALL cover reset mid-operation: pulse rst_n low in RUN with 2 entries queued -> reg_write=0 immediately, the entries are never written, and the clear sequence repeats from rd=1.
